// File: rtl/divider_seq_if.sv
// Handshake and result bundle for the sequential divider.
interface divider_seq_if;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        divZero;

  modport master (output start, Signal, dataA, dataB,
                  input  quotient, remainder, busy, done, divZero);
  modport slave  (input  start, Signal, dataA, dataB,
                  output quotient, remainder, busy, done, divZero);
endinterface

// File: rtl/divider_seq.sv
// Sequential 32-bit restoring divider (signed/unsigned), one quotient bit per cycle.
// Divide-by-zero short-circuits straight to FIN with all-ones quotient.
module divider_seq #(
  parameter logic [5:0] DIVU = 6'b011011,
  parameter logic [5:0] DIV  = 6'b011010
) (
  input logic          clk,
  input logic          rst_n,
  divider_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] pr_q, pr_d;     // partial remainder
  logic [31:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d;
  logic        dz_q, dz_d;

  logic        op_ok, is_s, ge;
  logic [32:0] trial;
  logic [31:0] diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    op_ok = bus.start && (bus.Signal == DIVU || bus.Signal == DIV);
    is_s  = (bus.Signal == DIV);
    trial = {pr_q, dvd_q[31]};
    ge    = (trial >= {1'b0, dvs_q});
    // When ge holds the difference is below 2^32, so 32-bit wraparound is exact.
    diff  = trial[31:0] - dvs_q;

    case (state_q)
      IDLE: begin
        if (op_ok) begin
          if (bus.dataB == 32'd0) begin
            state_d = FIN;
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = bus.dataA;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = 6'd0;
            pr_d    = 32'd0;
            dvd_d   = (is_s && bus.dataA[31]) ? -bus.dataA : bus.dataA;
            dvs_d   = (is_s && bus.dataB[31]) ? -bus.dataB : bus.dataB;
            negq_d  = is_s && (bus.dataA[31] ^ bus.dataB[31]);
            negr_d  = is_s && bus.dataA[31];
          end
        end
      end
      RUN: begin
        pr_d  = ge ? diff : trial[31:0];
        dvd_d = {dvd_q[30:0], ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIN;
          quo_d   = negq_q ? -dvd_d : dvd_d;
          rem_d   = negr_q ? -pr_d  : pr_d;
          dz_d    = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      pr_q    <= 32'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.divZero   = dz_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_divider_seq;
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] DIV  = 6'b011010;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  divider_seq_if bus ();
  divider_seq #(.DIVU(DIVU), .DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [5:0]  s;
    logic [31:0] a, b, q, r;
    logic        dz;
  } vec_t;

  vec_t tbl[8];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s == DIV) begin
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT idle; optionally pulses a foreign start at cycle inj.
  task automatic run_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input string nm, input int inj);
    int lat;
    bit got;
    lat = 0; got = 0;
    bus.start = 1'b1; bus.Signal = s; bus.dataA = a; bus.dataB = b;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      if (lat == inj) begin
        bus.start = 1'b1; bus.Signal = DIVU; bus.dataA = 32'h0000_5555; bus.dataB = 32'd0;
      end
      if (bus.done) got = 1;
    end
    bus.start = 1'b0;
    chk({nm, "_lat"}, lat, (b == 32'd0) ? 33'd1 : 33'd33);
    chk({nm, "_q"}, bus.quotient, eq);
    chk({nm, "_r"}, bus.remainder, er);
    chk({nm, "_dz"}, bus.divZero, edz);
    @(negedge clk);
    chk({nm, "_idle"}, {bus.busy, bus.done}, 2'b00);
    chk({nm, "_hold"}, {bus.quotient, bus.remainder}, {eq, er});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, a, b, pq, pr;
    logic        dz;
    logic [5:0]  s;
    int          seen;

    tbl[0] = '{DIVU, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[3] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    tbl[4] = '{DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    tbl[5] = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[6] = '{DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    tbl[7] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.Signal = 6'd0; bus.dataA = 32'd0; bus.dataB = 32'd0;
    #1;
    chk("reset_out", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.divZero}, 67'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz,
             $sformatf("tbl%0d", i), -1);

    // Start during RUN must not disturb the captured operands.
    run_op(DIVU, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, "inj_run", 10);

    // Unknown funct code is ignored; zero divisor would otherwise jump to FIN.
    pq = bus.quotient; pr = bus.remainder;
    bus.start = 1'b1; bus.Signal = 6'b100000; bus.dataA = 32'hDEAD_BEEF; bus.dataB = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("bad_sig_busy", {bus.busy, bus.done}, 2'b00);
    chk("bad_sig_hold", {bus.quotient, bus.remainder}, {pq, pr});
    bus.start = 1'b1; bus.dataB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("bad_sig2_busy", bus.busy, 1'b0);

    // Reset mid-RUN aborts and clears outputs asynchronously.
    bus.start = 1'b1; bus.Signal = DIVU; bus.dataA = 32'hFFFF_FFFF; bus.dataB = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.divZero}, 67'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("rst_no_done", seen, 0);
    run_op(DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "post_rst", -1);

    // Random operations, issued back-to-back.
    for (int i = 0; i < 40; i++) begin
      s = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        3:       b = -($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      model(s, a, b, q, r, dz);
      run_op(s, a, b, q, r, dz, $sformatf("rnd%0d", i), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
